// File: rtl/periph_pkg.sv
// Shared constants for the peripheral bus: register map, TCON bit positions
// and the UART transmitter state encoding.
package periph_pkg;

  localparam logic [31:0] ADDR_TH     = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL     = 32'h4000_0004;
  localparam logic [31:0] ADDR_TCON   = 32'h4000_0008;
  localparam logic [31:0] ADDR_LED    = 32'h4000_000C;
  localparam logic [31:0] ADDR_SWITCH = 32'h4000_0010;
  localparam logic [31:0] ADDR_DIGI   = 32'h4000_0014;
  localparam logic [31:0] ADDR_TXD    = 32'h4000_0018;
  localparam logic [31:0] ADDR_UCON   = 32'h4000_001C;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

  // Registers are word-aligned; the byte offset within a word is ignored.
  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/peripheral_bus_if.sv
// CPU load/store bus as seen by the peripheral block.
interface peripheral_bus_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output rd, wr, addr, wdata, input rdata);
  modport slave  (input rd, wr, addr, wdata, output rdata);
endinterface

// File: rtl/uart_tx_fsm.sv
// 8N1 UART transmitter, LSB first, each bit held BAUD_DIV clocks.
module uart_tx_fsm
  import periph_pkg::*;
#(
  parameter int BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done_pulse
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  uart_state_t   state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          bit_end;

  assign bit_end    = (baud_cnt == BAUD_LAST);
  assign busy       = (state != UART_IDLE);
  assign done_pulse = (state == UART_STOP) && bit_end;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= UART_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      baud_cnt <= (state == UART_IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
      unique case (state)
        UART_IDLE: begin
          tx <= 1'b1;
          if (start) begin
            state <= UART_START;
            shreg <= data;
            tx    <= 1'b0;
          end
        end
        UART_START: if (bit_end) begin
          state   <= UART_DATA;
          bit_cnt <= '0;
          tx      <= shreg[0];
          shreg   <= shreg >> 1;
        end
        UART_DATA: if (bit_end) begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state <= UART_STOP;
            tx    <= 1'b1;
          end else begin
            tx    <= shreg[0];
            shreg <= shreg >> 1;
          end
        end
        UART_STOP: if (bit_end) state <= UART_IDLE;
        default: state <= UART_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/peripheral_bus.sv
// Memory-mapped peripherals: timer with interrupt, LEDs, switches,
// seven-segment drive and a UART transmitter.
module peripheral_bus
  import periph_pkg::*;
#(
  parameter int BAUD_DIV = 5208
) (
  input  logic                   clk,
  input  logic                   reset,
  peripheral_bus_if.slave        bus,
  input  logic [7:0]             switch,
  output logic [7:0]             led,
  output logic [11:0]            digi,
  output logic                   uart_tx,
  output logic                   irqout
);

  logic [31:0] th, tl, wa;
  logic [2:0]  tcon;
  logic        done, busy, done_pulse, overflow;
  logic        wr_th, wr_tl, wr_tcon, wr_led, wr_digi, tx_start, rd_ucon;

  assign wa       = word_addr(bus.addr);
  assign wr_th    = bus.wr && (wa == ADDR_TH);
  assign wr_tl    = bus.wr && (wa == ADDR_TL);
  assign wr_tcon  = bus.wr && (wa == ADDR_TCON);
  assign wr_led   = bus.wr && (wa == ADDR_LED);
  assign wr_digi  = bus.wr && (wa == ADDR_DIGI);
  assign tx_start = bus.wr && (wa == ADDR_TXD);
  assign rd_ucon  = bus.rd && (wa == ADDR_UCON);

  assign overflow = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF);
  assign irqout   = tcon[TCON_IE] & tcon[TCON_IS];

  always_ff @(posedge clk) begin
    if (!reset) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
      led  <= '0;
      digi <= '0;
      done <= 1'b0;
    end else begin
      if (wr_th) th <= bus.wdata;
      // CPU store to TL beats the timer's own count/reload.
      if (wr_tl)               tl <= bus.wdata;
      else if (tcon[TCON_EN])  tl <= overflow ? th : tl + 32'd1;
      if (wr_tcon) begin
        tcon[TCON_EN] <= bus.wdata[TCON_EN];
        tcon[TCON_IE] <= bus.wdata[TCON_IE];
        // An overflow on the same edge must not be lost to a software clear.
        tcon[TCON_IS] <= bus.wdata[TCON_IS] | overflow;
      end else if (overflow) begin
        tcon[TCON_IS] <= 1'b1;
      end
      if (wr_led)  led  <= bus.wdata[7:0];
      if (wr_digi) digi <= bus.wdata[11:0];
      if (done_pulse)   done <= 1'b1;
      else if (rd_ucon) done <= 1'b0;
    end
  end

  uart_tx_fsm #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk        (clk),
    .reset      (reset),
    .start      (tx_start),
    .data       (bus.wdata[7:0]),
    .tx         (uart_tx),
    .busy       (busy),
    .done_pulse (done_pulse)
  );

  always_comb begin
    bus.rdata = '0;
    if (bus.rd) begin
      unique case (wa)
        ADDR_TH:     bus.rdata = th;
        ADDR_TL:     bus.rdata = tl;
        ADDR_TCON:   bus.rdata = {29'd0, tcon};
        ADDR_LED:    bus.rdata = {24'd0, led};
        ADDR_SWITCH: bus.rdata = {24'd0, switch};
        ADDR_DIGI:   bus.rdata = {20'd0, digi};
        ADDR_UCON:   bus.rdata = {30'd0, done, busy};
        default:     bus.rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_bus.sv
// Self-checking bench for peripheral_bus: register table, timer and UART
// corner sequences, and randomized traffic against a behavioural model.
module tb_peripheral_bus;

  localparam int BD = 4;
  localparam logic [31:0] A_TH = 32'h4000_0000, A_TL = 32'h4000_0004,
                          A_TCON = 32'h4000_0008, A_LED = 32'h4000_000C,
                          A_SW = 32'h4000_0010, A_DIGI = 32'h4000_0014,
                          A_TXD = 32'h4000_0018, A_UCON = 32'h4000_001C;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  switch;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        uart_tx, irqout;

  peripheral_bus_if bus_if ();

  peripheral_bus #(.BAUD_DIV(BD)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_if.slave),
    .switch  (switch),
    .led     (led),
    .digi    (digi),
    .uart_tx (uart_tx),
    .irqout  (irqout)
  );

  always #5 clk = ~clk;

  int vecs_applied = 0;
  int miscompares  = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  sw;
    logic [31:0] exp_rdata;
    logic [7:0]  exp_led;
    logic [11:0] exp_digi;
  } vec_t;

  vec_t tbl[16];

  // behavioural model state for randomized traffic
  logic [31:0] m_th, m_tl;
  logic [7:0]  m_led;
  logic [11:0] m_digi;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs_applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.wr = 1'b1; bus_if.addr = a; bus_if.wdata = d;
    @(posedge clk); #1;
    bus_if.wr = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus_if.rd = 1'b1; bus_if.addr = a;
    #1 chk(name, bus_if.rdata, exp);
    bus_if.rd = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  // Watch one full frame from the cycle after the TXD write edge.
  // If inject is set, a second TXD write is attempted partway through.
  task automatic watch_frame(input string name, input logic [7:0] b, input bit inject);
    int bad_bits, busy_cnt;
    bad_bits = 0; busy_cnt = 0;
    for (int i = 0; i < 10*BD; i++) begin
      if (uart_tx !== frame_bit(b, i / BD)) bad_bits++;
      if (dut.u_tx.busy === 1'b1) busy_cnt++;
      if (inject && i == 10) begin
        bus_if.wr = 1'b1; bus_if.addr = A_TXD; bus_if.wdata = 32'h55;
      end else begin
        bus_if.wr = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus_if.wr = 1'b0;
    chk({name, " bit errors"}, bad_bits, 0);
    chk({name, " busy cycles"}, busy_cnt, 10*BD);
    chk({name, " tx idle"}, {31'd0, uart_tx}, 1);
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [7:0] sw);
    case ({a[31:2], 2'b00})
      A_TH:    return m_th;
      A_TL:    return m_tl;
      A_TCON:  return 32'd0;
      A_LED:   return {24'd0, m_led};
      A_SW:    return {24'd0, sw};
      A_DIGI:  return {20'd0, m_digi};
      A_UCON:  return 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    reset = 1'b0; switch = 8'h00;
    bus_if.rd = 1'b0; bus_if.wr = 1'b0; bus_if.addr = '0; bus_if.wdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // reset state
    rd_chk("rst TH", A_TH, 0);
    rd_chk("rst TL", A_TL, 0);
    rd_chk("rst TCON", A_TCON, 0);
    rd_chk("rst LED", A_LED, 0);
    rd_chk("rst DIGI", A_DIGI, 0);
    rd_chk("rst UCON", A_UCON, 0);
    chk("rst uart_tx", {31'd0, uart_tx}, 1);
    chk("rst irqout", {31'd0, irqout}, 0);

    // register table: rd, wr, addr, wdata, switch, rdata, led, digi
    tbl[0]  = '{1'b0, 1'b1, A_LED,         32'hA5,       8'h00, 32'h0,        8'hA5, 12'h000};
    tbl[1]  = '{1'b1, 1'b0, A_LED,         32'h0,        8'h00, 32'hA5,       8'hA5, 12'h000};
    tbl[2]  = '{1'b0, 1'b1, 32'h4000_000F, 32'h1FF,      8'h00, 32'h0,        8'hFF, 12'h000};
    tbl[3]  = '{1'b1, 1'b0, A_LED,         32'h0,        8'h00, 32'hFF,       8'hFF, 12'h000};
    tbl[4]  = '{1'b1, 1'b0, A_SW,          32'h0,        8'h3C, 32'h3C,       8'hFF, 12'h000};
    tbl[5]  = '{1'b0, 1'b1, A_SW,          32'h12,       8'h3C, 32'h0,        8'hFF, 12'h000};
    tbl[6]  = '{1'b1, 1'b0, 32'h4000_0012, 32'h0,        8'h3C, 32'h3C,       8'hFF, 12'h000};
    tbl[7]  = '{1'b1, 1'b0, 32'h4000_0040, 32'h0,        8'h3C, 32'h0,        8'hFF, 12'h000};
    tbl[8]  = '{1'b0, 1'b0, A_SW,          32'h0,        8'h3C, 32'h0,        8'hFF, 12'h000};
    tbl[9]  = '{1'b0, 1'b1, A_DIGI,        32'hFFFFF,    8'h00, 32'h0,        8'hFF, 12'hFFF};
    tbl[10] = '{1'b1, 1'b0, A_DIGI,        32'h0,        8'h00, 32'hFFF,      8'hFF, 12'hFFF};
    tbl[11] = '{1'b1, 1'b0, A_TXD,         32'h0,        8'h00, 32'h0,        8'hFF, 12'hFFF};
    tbl[12] = '{1'b0, 1'b1, 32'h4000_0040, 32'h0,        8'h00, 32'h0,        8'hFF, 12'hFFF};
    tbl[13] = '{1'b1, 1'b0, A_UCON,        32'h0,        8'h00, 32'h0,        8'hFF, 12'hFFF};
    tbl[14] = '{1'b0, 1'b1, A_TH,          32'h12345678, 8'h00, 32'h0,        8'hFF, 12'hFFF};
    tbl[15] = '{1'b1, 1'b0, A_TH,          32'h0,        8'h00, 32'h12345678, 8'hFF, 12'hFFF};
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus_if.rd = tbl[i].rd; bus_if.wr = tbl[i].wr;
      bus_if.addr = tbl[i].addr; bus_if.wdata = tbl[i].wdata; switch = tbl[i].sw;
      #1 chk($sformatf("tbl[%0d] rdata", i), bus_if.rdata, tbl[i].exp_rdata);
      @(posedge clk); #1;
      chk($sformatf("tbl[%0d] led", i), {24'd0, led}, {24'd0, tbl[i].exp_led});
      chk($sformatf("tbl[%0d] digi", i), {20'd0, digi}, {20'd0, tbl[i].exp_digi});
      bus_if.rd = 1'b0; bus_if.wr = 1'b0;
    end

    // timer overflow, reload and interrupt
    wr_reg(A_TH, 32'hFFFF_FFFE);
    wr_reg(A_TL, 32'hFFFF_FFFE);
    wr_reg(A_TCON, 32'd3);
    chk("irq edge0", {31'd0, irqout}, 0);
    @(posedge clk); #1;
    chk("irq edge1", {31'd0, irqout}, 0);
    @(posedge clk); #1;
    chk("irq edge2", {31'd0, irqout}, 1);
    rd_chk("TL reload", A_TL, 32'hFFFF_FFFE);
    wr_reg(A_TCON, 32'd3);
    chk("irq cleared", {31'd0, irqout}, 0);
    rd_chk("TCON cleared", A_TCON, 3);
    wr_reg(A_TCON, 32'd3);
    rd_chk("TCON clr vs ovf", A_TCON, 7);
    chk("irq kept", {31'd0, irqout}, 1);
    wr_reg(A_TL, 32'd5);
    rd_chk("TL cpu wins", A_TL, 5);

    // UART frame, ignored write while busy, done flag
    do_reset();
    wr_reg(A_TXD, 32'hA5);
    watch_frame("frame A5", 8'hA5, 1'b1);
    bus_if.rd = 1'b1; bus_if.addr = A_UCON;
    #1 chk("UCON done", bus_if.rdata, 2);
    @(posedge clk); #1;
    chk("UCON cleared", bus_if.rdata, 0);
    bus_if.rd = 1'b0;

    // reset mid-frame (during data bit 3)
    wr_reg(A_LED, 32'h3C);
    wr_reg(A_TXD, 32'h0F);
    repeat (4*BD + 1) @(posedge clk);
    do_reset();
    chk("mid rst tx", {31'd0, uart_tx}, 1);
    rd_chk("mid rst UCON", A_UCON, 0);
    rd_chk("mid rst LED", A_LED, 0);
    rd_chk("mid rst TL", A_TL, 0);
    chk("mid rst irq", {31'd0, irqout}, 0);

    // randomized register traffic, timer disabled
    m_th = 0; m_tl = 0; m_led = 0; m_digi = 0;
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a, d;
      logic [7:0]  sw;
      int          sel;
      bit          do_wr;
      sel = $urandom_range(0, 7);
      case (sel)
        0: a = A_TH; 1: a = A_TL; 2: a = A_LED; 3: a = A_SW;
        4: a = A_DIGI; 5: a = A_UCON;
        default: a = 32'h4000_0020 + 32'($urandom_range(0, 15) * 4);
      endcase
      a = a | 32'($urandom_range(0, 3));
      d = $urandom; sw = 8'($urandom); do_wr = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      switch = sw; bus_if.addr = a; bus_if.wdata = d;
      bus_if.rd = !do_wr; bus_if.wr = do_wr;
      #1 chk($sformatf("rnd[%0d] rdata", i), bus_if.rdata, do_wr ? 32'd0 : model_read(a, sw));
      @(posedge clk); #1;
      bus_if.rd = 1'b0; bus_if.wr = 1'b0;
      if (do_wr) begin
        case ({a[31:2], 2'b00})
          A_TH:   m_th = d;
          A_TL:   m_tl = d;
          A_LED:  m_led = d[7:0];
          A_DIGI: m_digi = d[11:0];
          default: ;
        endcase
      end
      chk($sformatf("rnd[%0d] led", i), {24'd0, led}, {24'd0, m_led});
    end

    // randomized frame
    begin
      logic [7:0] b;
      b = 8'($urandom);
      wr_reg(A_TXD, {24'd0, b});
      watch_frame("frame rnd", b, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs_applied, miscompares);
    $finish;
  end

endmodule

// File: doc/peripheral_bus.md
PERIPHERAL_BUS -- requirements
Module: peripheral_bus

Interface
REQ-001 Parameter BAUD_DIV, default 5208, clocks per UART bit (50 MHz / 9600 baud).
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 rd  in  1  CPU load strobe; wr  in  1  CPU store strobe.
REQ-005 addr  in  32  byte address; wdata  in  32  store data; rdata  out  32  load data.
REQ-006 switch  in  8  board switches; led  out  8; digi  out  12  seven-segment drive.
REQ-007 uart_tx  out  1  serial line; irqout  out  1  timer interrupt request to CPU.

Function
REQ-008 Register map, word-aligned, addr[1:0] ignored: 0x40000000 TH rw; 0x40000004 TL rw; 0x40000008 TCON[2:0] rw; 0x4000000C LED[7:0] rw; 0x40000010 SWITCH[7:0] ro; 0x40000014 DIGI[11:0] rw; 0x40000018 TXD[7:0] wo; 0x4000001C UCON[1:0] ro.
REQ-009 rdata combinational: register value zero-extended when rd=1 and address mapped; 0 when rd=0, address unmapped, or TXD read.
REQ-010 Writes take effect at the clk edge with wr=1; unmapped addresses and read-only registers ignore writes.
REQ-011 TCON bits: [0] timer enable, [1] interrupt enable, [2] interrupt status.
REQ-012 Timer, TCON[0]=1: TL=0xFFFFFFFF -> TL<=TH and TCON[2]<=1 in the same edge; otherwise TL<=TL+1.
REQ-013 CPU write to TL in the same cycle as a count or reload: CPU value wins.
REQ-014 CPU write to TCON in the same cycle as an overflow: bits [1:0] take wdata, bit [2] is set to 1 (no lost interrupt).
REQ-015 irqout = TCON[1] & TCON[2], combinational; software clears it by writing TCON[2]=0.
REQ-016 UART transmitter FSM states: IDLE, START, DATA, STOP; 8N1 frame, LSB first, each bit held exactly BAUD_DIV clocks.
REQ-017 Write to TXD in IDLE latches wdata[7:0]; FSM enters START on that edge; uart_tx low from the next cycle.
REQ-018 Write to TXD outside IDLE is ignored; the in-flight frame is unaffected.
REQ-019 Bit counter 3 bits, wraps 7->DATA exit; baud counter counts 0..BAUD_DIV-1 and wraps to 0 on each bit boundary.
REQ-020 STOP lasts BAUD_DIV clocks with uart_tx=1, then IDLE; full frame = 10*BAUD_DIV clocks; back-to-back TXD write accepted the first IDLE cycle.
REQ-021 UCON[0] busy = (state != IDLE); UCON[1] done, set at STOP exit, cleared at any edge with rd=1 to UCON; set wins over clear when both occur on the same edge.
REQ-022 uart_tx = 1 in IDLE.

Reset
REQ-023 With reset=0 at a clk edge: TH, TL, TCON, LED, DIGI, TXD latch, counters <= 0; FSM <= IDLE; done <= 0.
REQ-024 Reset mid-frame aborts the frame; uart_tx = 1 from the following cycle; irqout = 0 and busy = 0 after reset.
REQ-025 Reset overrides any simultaneous wr.

Structure
REQ-026 Register addresses, TCON bit indices and UART state encodings live in shared package periph_pkg.
REQ-027 Transmitter is sub-module uart_tx_fsm (ports clk, reset, start, data[7:0], tx, busy, done_pulse); timer, register decode and readback stay in peripheral_bus.

Verification
REQ-028 BAUD_DIV=4; TH=0xFFFFFFFE, TL=0xFFFFFFFE, TCON=3 -> irqout rises 2 edges later, TL reads 0xFFFFFFFE; write TCON=3 -> irqout 0.
REQ-029 Overflow edge coincides with a TCON=3 write -> TCON reads 7, irqout stays 1.
REQ-030 BAUD_DIV=4; write TXD=0xA5 -> uart_tx sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; busy 40 cycles; UCON reads 2 then 0 on a second read.
REQ-031 TXD=0x55 written while busy -> ignored, frame bits unchanged.
REQ-032 reset=0 pulsed at bit 3 of a frame -> uart_tx=1, UCON=0, LED=0, TL=0 the next cycle.
REQ-033 switch=0x3C, rd at 0x40000010 -> rdata=0x0000003C; rd at 0x40000040 -> rdata=0; rd=0 -> rdata=0.
